// File: rtl/axiuart_pkg.sv
// Shared definitions for the UART-AXI4 bridge.
// Holds the 8-bit response status codes, the transfer size encoding,
// the AXI response code for OKAY and the transaction engine state type.
package axiuart_pkg;

  localparam logic [7:0] STS_OK         = 8'h00;
  localparam logic [7:0] STS_CMD_INV    = 8'h02;
  localparam logic [7:0] STS_ADDR_ALIGN = 8'h03;
  localparam logic [7:0] STS_TIMEOUT    = 8'h04;
  localparam logic [7:0] STS_AXI_ERR    = 8'h05;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    SIZE_8  = 2'b00,
    SIZE_16 = 2'b01,
    SIZE_32 = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BUS,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RESP
  } state_e;

endpackage

// File: rtl/axi_lite_lane_mux.sv
// Byte-lane placement for a 32-bit AXI4-Lite data bus.
// Ports:
//   addr_lo   - byte offset within the word (address bits [1:0])
//   size      - transfer size (00=8b, 01=16b, 10=32b)
//   wdata_in  - right-justified write data
//   wdata_out - write data shifted onto its byte lanes
//   rdata_in  - raw bus read data
//   rdata_out - read data shifted down and zero-extended to the size
module axi_lite_lane_mux
  import axiuart_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata_in,
  output logic [31:0] wdata_out,
  input  logic [31:0] rdata_in,
  output logic [31:0] rdata_out
);

  logic [4:0]  shift;
  logic [31:0] rshift;

  always_comb begin
    shift     = {addr_lo, 3'b000};
    wdata_out = wdata_in << shift;
    rshift    = rdata_in >> shift;
    case (size)
      SIZE_8:  rdata_out = {24'h0, rshift[7:0]};
      SIZE_16: rdata_out = {16'h0, rshift[15:0]};
      default: rdata_out = rshift;
    endcase
  end

endmodule

// File: rtl/axi_lite_txn_engine.sv
// AXI4-Lite master stage of the UART-AXI4 bridge. Takes one decoded command
// (with its alignment verdict and strobe), runs a single write or read on the
// bus, or rejects it without bus traffic, and returns one status/data response.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   cmd_*                       - command handshake and fields
//   align_ok/_wstrb/_status     - aligner verdict for the command
//   m_axi_aw*/w*/b*/ar*/r*      - AXI4-Lite master channels
//   rsp_valid/ready/status/rdata- response to the frame builder
// Optional feature: define AXI_TXN_ENGINE_TIMEOUT_EN to enable the per
// transaction bus timeout (status 0x04). Without it the engine waits forever.
module axi_lite_txn_engine
  import axiuart_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  align_ok,
  input  logic [3:0]            align_wstrb,
  input  logic [2:0]            align_status,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [7:0]            rsp_status,
  output logic [31:0]           rsp_rdata
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wstrb_q;
  logic                  aw_done_q, w_done_q;
  logic [7:0]            rsp_status_q;
  logic [31:0]           rsp_rdata_q;

  logic                  accept, rsp_load, aw_fire, w_fire, tmo_hit;
  logic [7:0]            sts_d;
  logic [31:0]           rdata_d, rd_extract;

  axi_lite_lane_mux u_lane_mux (
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .wdata_in  (wdata_q),
    .wdata_out (m_axi_wdata),
    .rdata_in  (m_axi_rdata),
    .rdata_out (rd_extract)
  );

`ifdef AXI_TXN_ENGINE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             in_bus;

  assign in_bus  = (state_q == ST_WR_BUS) || (state_q == ST_WR_RESP) ||
                   (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
  assign tmo_hit = in_bus && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Saturates at the limit so a handshake that wins the timeout cycle still
  // leaves the following phase with an already-expired budget.
  always_ff @(posedge clk) begin
    if (rst || accept)
      tmo_cnt_q <= '0;
    else if (in_bus && (tmo_cnt_q != CNT_W'(TIMEOUT_CYCLES)))
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    accept        = 1'b0;
    rsp_load      = 1'b0;
    aw_fire       = 1'b0;
    w_fire        = 1'b0;
    sts_d         = STS_OK;
    rdata_d       = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          if (!align_ok) begin
            state_d  = ST_RESP;
            rsp_load = 1'b1;
            sts_d    = {5'b0, align_status};
          end else if (cmd_rw) begin
            state_d = ST_RD_ADDR;
          end else begin
            state_d = ST_WR_BUS;
          end
        end
      end
      ST_WR_BUS: begin
        m_axi_awvalid = !aw_done_q;
        m_axi_wvalid  = !w_done_q;
        aw_fire       = m_axi_awvalid && m_axi_awready;
        w_fire        = m_axi_wvalid && m_axi_wready;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          state_d = ST_WR_RESP;
        end else if (tmo_hit) begin
          state_d  = ST_RESP;
          rsp_load = 1'b1;
          sts_d    = STS_TIMEOUT;
        end
      end
      ST_WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          state_d  = ST_RESP;
          rsp_load = 1'b1;
          sts_d    = (m_axi_bresp == AXI_RESP_OKAY) ? STS_OK : STS_AXI_ERR;
        end else if (tmo_hit) begin
          state_d  = ST_RESP;
          rsp_load = 1'b1;
          sts_d    = STS_TIMEOUT;
        end
      end
      ST_RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_d = ST_RD_DATA;
        end else if (tmo_hit) begin
          state_d  = ST_RESP;
          rsp_load = 1'b1;
          sts_d    = STS_TIMEOUT;
        end
      end
      ST_RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          state_d  = ST_RESP;
          rsp_load = 1'b1;
          if (m_axi_rresp == AXI_RESP_OKAY) begin
            sts_d   = STS_OK;
            rdata_d = rd_extract;
          end else begin
            sts_d   = STS_AXI_ERR;
          end
        end else if (tmo_hit) begin
          state_d  = ST_RESP;
          rsp_load = 1'b1;
          sts_d    = STS_TIMEOUT;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rsp_status_q <= 8'h00;
      rsp_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_fire) aw_done_q <= 1'b1;
        if (w_fire)  w_done_q  <= 1'b1;
      end
      if (rsp_load) begin
        rsp_status_q <= sts_d;
        rsp_rdata_q  <= rdata_d;
      end
    end
  end

  // Command fields are only meaningful after acceptance; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= cmd_addr;
      size_q  <= cmd_size;
      wdata_q <= cmd_wdata;
      wstrb_q <= align_wstrb;
    end
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wstrb  = wstrb_q;
  assign rsp_status   = rsp_status_q;
  assign rsp_rdata    = rsp_rdata_q;

endmodule

// File: tb/tb_axi_lite_txn_engine.sv
// Directed bench for axi_lite_txn_engine with hand-computed expectations.
module tb_axi_lite_txn_engine;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        align_ok;
  logic [3:0]  align_wstrb;
  logic [2:0]  align_status;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_status;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  axi_lite_txn_engine #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .align_ok(align_ok), .align_wstrb(align_wstrb), .align_status(align_status),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .m_axi_araddr(araddr), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_rdata(rsp_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus monitor: handshakes seen at negedge complete on the next posedge.
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, rsp_hs = 0, aw_seen = 0, ar_seen = 0;
  logic [31:0] awaddr_cap = '0, wdata_cap = '0, araddr_cap = '0;
  logic [3:0]  wstrb_cap = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (awvalid) aw_seen++;
      if (arvalid) ar_seen++;
      if (awvalid && awready) begin aw_hs++; awaddr_cap = awaddr; end
      if (wvalid && wready) begin w_hs++; wdata_cap = wdata; wstrb_cap = wstrb; end
      if (arvalid && arready) begin ar_hs++; araddr_cap = araddr; end
      if (rsp_valid && rsp_ready) rsp_hs++;
    end
  end

  int b_aw, b_w, b_ar, b_rsp, b_aws, b_ars;
  int lat;

  task automatic snap();
    b_aw = aw_hs; b_w = w_hs; b_ar = ar_hs; b_rsp = rsp_hs; b_aws = aw_seen; b_ars = ar_seen;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic slave(input logic awr, input logic wr, input logic bv, input logic [1:0] br,
                       input logic arr, input logic rv, input logic [1:0] rr, input logic [31:0] rd);
    awready = awr; wready = wr; bvalid = bv; bresp = br;
    arready = arr; rvalid = rv; rresp = rr; rdata = rd;
  endtask

  task automatic issue(input string tag, input logic rw, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, input logic ok, input logic [3:0] st, input logic [2:0] as);
    cmd_rw = rw; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    align_ok = ok; align_wstrb = st; align_status = as;
    cmd_valid = 1'b1;
    check_val({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
    step();
    cmd_valid = 1'b0;
  endtask

  // lat = cycles after the acceptance cycle until rsp_valid is seen.
  task automatic wait_rsp(input string tag, output int l);
    l = 1;
    while (!rsp_valid && l < 64) begin
      step();
      l++;
    end
    check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
  endtask

  task automatic take_rsp(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_val({tag, "_back_idle"}, 32'({rsp_valid, cmd_ready}), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_wdata = '0; align_ok = 1'b0; align_wstrb = '0; align_status = '0;
    rsp_ready = 1'b0;
    slave(0, 0, 0, 2'b00, 0, 0, 2'b00, 32'h0);
    repeat (3) step();
    check_val("rst_ctrl", 32'({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}), 32'h40);
    check_val("rst_status", 32'(rsp_status), 32'h0);
    check_val("rst_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    step();

    // 16-bit write at byte 2, zero-wait slave
    slave(1, 1, 1, 2'b00, 1, 1, 2'b00, 32'h0);
    snap();
    issue("wr16", 1'b0, 32'h2, 2'b01, 32'h0000_BEEF, 1'b1, 4'b1100, 3'd0);
    wait_rsp("wr16", lat);
    check_val("wr16_lat", lat, 3);
    check_val("wr16_status", 32'(rsp_status), 32'h00);
    check_val("wr16_rdata", rsp_rdata, 32'h0);
    check_val("wr16_wdata", wdata_cap, 32'hBEEF_0000);
    check_val("wr16_wstrb", 32'(wstrb_cap), 32'hC);
    check_val("wr16_awaddr", awaddr_cap, 32'h2);
    check_val("wr16_hs", (aw_hs - b_aw) * 16 + (w_hs - b_w), 17);
    take_rsp("wr16");

    // 8-bit read at byte 3
    slave(1, 1, 1, 2'b00, 1, 1, 2'b00, 32'h1122_3344);
    issue("rd8", 1'b1, 32'h3, 2'b00, 32'h0, 1'b1, 4'b1000, 3'd0);
    wait_rsp("rd8", lat);
    check_val("rd8_lat", lat, 3);
    check_val("rd8_status", 32'(rsp_status), 32'h00);
    check_val("rd8_rdata", rsp_rdata, 32'h0000_0011);
    check_val("rd8_araddr", araddr_cap, 32'h3);
    take_rsp("rd8");

    // alignment reject: no bus traffic
    snap();
    issue("rej", 1'b1, 32'h1, 2'b10, 32'h0, 1'b0, 4'b0000, 3'd3);
    wait_rsp("rej", lat);
    check_val("rej_lat", lat, 1);
    check_val("rej_status", 32'(rsp_status), 32'h03);
    check_val("rej_rdata", rsp_rdata, 32'h0);
    check_val("rej_no_bus", (aw_seen - b_aws) + (ar_seen - b_ars), 0);
    take_rsp("rej");

    // AW accepted 5 cycles before W
    slave(1, 0, 1, 2'b00, 1, 1, 2'b00, 32'h0);
    snap();
    issue("split", 1'b0, 32'h100, 2'b10, 32'h1234_5678, 1'b1, 4'hF, 3'd0);
    check_val("split_both", 32'({awvalid, wvalid}), 32'h3);
    step();
    for (int i = 0; i < 4; i++) begin
      check_val("split_w_held", 32'({awvalid, wvalid}), 32'h1);
      step();
    end
    wready = 1'b1;
    wait_rsp("split", lat);
    check_val("split_status", 32'(rsp_status), 32'h00);
    check_val("split_wdata", wdata_cap, 32'h1234_5678);
    check_val("split_hs", (aw_hs - b_aw) * 16 + (w_hs - b_w), 17);
    take_rsp("split");
    repeat (3) step();
    check_val("split_one_rsp", (rsp_hs - b_rsp) * 2 + 32'(rsp_valid), 2);

    // 16-bit read at byte 2
    slave(1, 1, 1, 2'b00, 1, 1, 2'b00, 32'hAABB_CCDD);
    issue("rd16", 1'b1, 32'h2, 2'b01, 32'h0, 1'b1, 4'b1100, 3'd0);
    wait_rsp("rd16", lat);
    check_val("rd16_rdata", rsp_rdata, 32'h0000_AABB);
    take_rsp("rd16");

    // 8-bit write at byte 1 with SLVERR response
    slave(1, 1, 1, 2'b10, 1, 1, 2'b00, 32'h0);
    issue("wrerr", 1'b0, 32'h41, 2'b00, 32'h0000_005A, 1'b1, 4'b0010, 3'd0);
    wait_rsp("wrerr", lat);
    check_val("wrerr_wdata", wdata_cap, 32'h0000_5A00);
    check_val("wrerr_status", 32'(rsp_status), 32'h05);
    check_val("wrerr_rdata", rsp_rdata, 32'h0);
    take_rsp("wrerr");

    // read SLVERR with response held off for 4 cycles
    slave(1, 1, 1, 2'b00, 1, 1, 2'b10, 32'hDEAD_BEEF);
    issue("rderr", 1'b1, 32'h4, 2'b10, 32'h0, 1'b1, 4'hF, 3'd0);
    wait_rsp("rderr", lat);
    for (int i = 0; i < 4; i++) begin
      check_val("rderr_hold_ctrl", 32'({rsp_valid, cmd_ready}), 32'h2);
      check_val("rderr_hold_status", 32'(rsp_status), 32'h05);
      check_val("rderr_hold_rdata", rsp_rdata, 32'h0);
      step();
    end
    take_rsp("rderr");

`ifdef AXI_TXN_ENGINE_TIMEOUT_EN
    // slave never grants AR
    slave(1, 1, 1, 2'b00, 0, 1, 2'b00, 32'h0);
    snap();
    issue("tmo", 1'b1, 32'h8, 2'b10, 32'h0, 1'b1, 4'hF, 3'd0);
    wait_rsp("tmo", lat);
    check_val("tmo_lat", lat, 18);
    check_val("tmo_status", 32'(rsp_status), 32'h04);
    check_val("tmo_rdata", rsp_rdata, 32'h0);
    check_val("tmo_arvalid", 32'(arvalid), 32'h0);
    check_val("tmo_no_ar_hs", ar_hs - b_ar, 0);
    take_rsp("tmo");
    slave(1, 1, 1, 2'b00, 1, 1, 2'b00, 32'h5566_7788);
    issue("tmo_after", 1'b1, 32'h8, 2'b10, 32'h0, 1'b1, 4'hF, 3'd0);
    wait_rsp("tmo_after", lat);
    check_val("tmo_after_lat", lat, 3);
    check_val("tmo_after_status", 32'(rsp_status), 32'h00);
    check_val("tmo_after_rdata", rsp_rdata, 32'h5566_7788);
    take_rsp("tmo_after");
`endif

    // reset in the middle of a write abandons it
    slave(0, 0, 0, 2'b00, 0, 0, 2'b00, 32'h0);
    issue("mrst", 1'b0, 32'h10, 2'b10, 32'h1111_2222, 1'b1, 4'hF, 3'd0);
    step();
    check_val("mrst_busy", 32'(awvalid), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("mrst_ctrl", 32'({cmd_ready, rsp_valid, awvalid, wvalid}), 32'h8);
    repeat (3) step();
    check_val("mrst_no_rsp", 32'(rsp_valid), 32'h0);
    slave(1, 1, 1, 2'b00, 1, 1, 2'b00, 32'h0);
    issue("post_rst", 1'b0, 32'h0, 2'b10, 32'hCAFE_F00D, 1'b1, 4'hF, 3'd0);
    wait_rsp("post_rst", lat);
    check_val("post_rst_lat", lat, 3);
    check_val("post_rst_wdata", wdata_cap, 32'hCAFE_F00D);
    check_val("post_rst_status", 32'(rsp_status), 32'h00);
    take_rsp("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_txn_engine.md
# axi_lite_txn_engine

Downstream AXI4-Lite master stage of the UART-AXI4 bridge. Accepts one decoded command per handshake together with the address-alignment verdict and write strobe computed for that command. Runs a single AXI4-Lite write or read with byte-lane placement, or rejects the command without bus traffic, and returns one status/data response to the frame builder. Only one transaction is outstanding at a time.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (fixed 32; four byte lanes)
- TIMEOUT_CYCLES, 1024, bus cycles allowed per transaction before timeout
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous and active-high
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_rw  in  1  1=read, 0=write
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_size  in  2  00=8b, 01=16b, 10=32b
- cmd_wdata  in  32  write data, right-justified
- align_ok / align_wstrb / align_status  in  1/4/3  aligner verdict for cmd_addr/cmd_size, valid with cmd_valid
- m_axi_aw{addr,valid,ready}, m_axi_w{data,strb,valid,ready}, m_axi_b{resp,valid,ready}  AXI4-Lite write channels
- m_axi_ar{addr,valid,ready}, m_axi_r{data,resp,valid,ready}  AXI4-Lite read channels
- rsp_valid / rsp_ready  out/in  1  response handshake
- rsp_status  out  8  0x00 OK, 0x02 CMD_INV, 0x03 ADDR_ALIGN, 0x04 TIMEOUT, 0x05 AXI_ERR
- rsp_rdata  out  32  read data, right-justified and zero-extended; 0 for writes and errors

## Operation
- States: IDLE, WR_BUS, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch addr, size, rw, wdata, align_wstrb, align_status and clear the timeout counter.
  - !align_ok → RESP with rsp_status={5'b0,align_status}; no AXI traffic.
  - Else write → WR_BUS; read → RD_ADDR.
- WR_BUS: awvalid and wvalid asserted together in the same cycle. Each drops independently on its own handshake. Both done → WR_RESP.
  - wdata = latched wdata << (addr[1:0]*8); wstrb = latched strobe.
- WR_RESP: bready=1. On bvalid → RESP with status 0x00 if bresp==OKAY, else 0x05.
- RD_ADDR: arvalid until arready → RD_DATA. rready=1 in RD_DATA.
- RD_DATA: on rvalid, rsp_rdata = (rdata >> addr[1:0]*8) masked to 8/16/32 bits by size. Status 0x00 if rresp==OKAY; otherwise 0x05 with rdata 0.
- RESP: rsp_valid held, and outputs stable, until rsp_ready → IDLE.
- awaddr/araddr carry the full byte address unmodified.

## Timing
- Reset values: all valids/readies 0 except cmd_ready=1; rsp_status 0; rsp_rdata 0; state IDLE; counter 0. Reset mid-transaction abandons it immediately; no response is produced.
- The AXI valid is asserted in the cycle after command acceptance. Best-case write: accept → WR_BUS (1) → WR_RESP (1) → RESP. rsp_valid appears 3 cycles after acceptance with zero-wait slave.
- Rejected command: rsp_valid one cycle after acceptance.
- AXI rule: a valid, once asserted, never drops before its ready, except on timeout.
- Timeout counter increments each cycle in WR_BUS/WR_RESP/RD_ADDR/RD_DATA. When it equals TIMEOUT_CYCLES:
  - all AXI valids/readies drop the next cycle;
  - state → RESP with status 0x04.
- A handshake completing in the same cycle as the timeout wins; no timeout is reported.
- Counter is wide enough to hold TIMEOUT_CYCLES without wrap. A response held in RESP is never timed out.

## Configuration
- AXI_TXN_ENGINE_TIMEOUT_EN defined: timeout counter and 0x04 path are present.
- Undefined: counter is removed, the engine waits indefinitely for each handshake, and status 0x04 is never produced.

## Structure
- Shared package axiuart_pkg holds:
  - the 8-bit status code constants (0x00/0x02/0x03/0x04/0x05);
  - the size encoding;
  - the state enum typedef.
- One sub-module, axi_lite_lane_mux: combinational write-lane shift and read extract/mask from addr[1:0] and size.

## Test plan
- Write 0x0000_0002, size 01, data 0xBEEF, strb 1100 → wdata 0xBEEF_0000, wstrb 1100, bresp OKAY → status 0x00, rdata 0.
- Read 0x0000_0003, size 00, slave rdata 0x11223344 → rsp_rdata 0x0000_0011, status 0x00.
- align_ok=0, align_status=3 → no aw/ar valid ever; rsp_valid next cycle with status 0x03.
- AW ready 5 cycles before W ready → awvalid drops on its handshake, wvalid held until its own; single response.
- Slave never asserts arready, TIMEOUT_CYCLES=16 → arvalid drops, status 0x04; a following command completes normally.
- Read with rresp=SLVERR and rsp_ready held low for 4 cycles → status 0x05 held stable, rdata 0, cmd_ready stays 0 until the response is accepted.
